txpause_gate: RTL and testbench
===============================

Name: txpause_gate

Overview:
- TX-side companion to the receive pause detector; sits on the TX AXIS path between user logic and the XGMII encoder.
- Consumes rx_pause_active and holds user frames at a frame boundary while the link partner has paused us.
- Also inserts locally requested 802.3x PAUSE frames (XOFF/XON) between user frames. PAUSE frames are exempt from gating.

Parameters:
- none

Ports:
- clk  in  1  TX clock (156.25 MHz)
- rst  in  1  synchronous, active-high reset
- tdata_i  in  64  user TX data; byte n on bits [8n+7:8n], byte 0 first on wire
- tkeep_i  in  8  byte enables
- tvalid_i  in  1  user valid
- tlast_i  in  1  end of frame
- tuser_i  in  1  pass-through (1 = good frame)
- tready_o  out  1  ready to user
- tdata_o  out  64  to encoder
- tkeep_o  out  8  to encoder
- tvalid_o  out  1  to encoder
- tlast_o  out  1  to encoder
- tuser_o  out  1  to encoder
- tready_i  in  1  encoder ready
- rx_pause_active  in  1  from RX pause detector; 1 = stop user TX
- cfg_tx_pause_enable  in  1  honour rx_pause_active when 1
- cfg_src_mac  in  48  station MAC; [47:40] is first byte on wire
- tx_pause_req  in  1  one-cycle pulse: send a PAUSE frame
- tx_pause_quanta  in  16  quanta sampled with tx_pause_req (0 = XON)
- tx_pause_busy  out  1  request pending or PAUSE frame in flight

Behaviour:
- States: S_IDLE (frame boundary), S_DATA (user frame passing), S_PFRAME (PAUSE frame), S_HOLD (user traffic blocked).
- S_IDLE priority:
  1. pending request → S_PFRAME, beat counter = 0.
  2. else if cfg_tx_pause_enable && rx_pause_active → S_HOLD.
  3. else if tvalid_i → pass-through; when tvalid_i && tready_i && !tlast_i → S_DATA. A single-beat frame (tlast_i) stays in S_IDLE.
- S_DATA: combinational pass-through, 0-cycle latency.
  - tvalid_o = tvalid_i, tready_o = tready_i; data, keep, last and user are copied.
  - rx_pause_active is ignored; the frame always completes.
  - On tvalid_i && tready_i && tlast_i → S_IDLE.
- S_HOLD: tready_o = 0, tvalid_o = 0.
  - Pending request → S_PFRAME.
  - Pause drop or cfg_tx_pause_enable = 0 → S_IDLE.
- S_PFRAME: tready_o = 0, tvalid_o = 1. Frame is 8 beats (60 bytes, FCS added downstream). Beat counter (3 bit) advances only on tready_i.
  - beat0: bytes 0-5 = 01 80 C2 00 00 01; bytes 6-7 = cfg_src_mac[47:32]; tkeep FF.
  - beat1: bytes 8-11 = cfg_src_mac[31:0]; bytes 12-13 = 88 08; bytes 14-15 = 00 01.
  - beat2: byte16 = quanta[15:8], byte17 = quanta[7:0]; remaining bytes 0.
  - beats 3-6: all zero, tkeep FF.
  - beat7: zero data, tkeep 0F, tlast = 1.
  - All beats: tuser_o = 1.
  - After beat7 accepted → S_IDLE (re-evaluates pending/hold the same way).
- Request latch:
  - tx_pause_req sets pending and captures quanta into the pending register.
  - A new req while pending overwrites the quanta, so only the latest value is sent.
  - On entry to S_PFRAME, the pending quanta moves to the active register and pending clears. A req arriving on that same cycle wins and re-sets pending.
  - A req during S_PFRAME queues exactly one further frame.
- tx_pause_busy = pending | (state == S_PFRAME).
- Outputs are only driven with valid data when tvalid_o = 1; otherwise tdata_o, tkeep_o, tlast_o and tuser_o are 0.
- Reset (including mid-frame): state S_IDLE, pending = 0, quanta registers = 0, beat counter = 0, tready_o = 0 during reset, tvalid_o = 0, tx_pause_busy = 0. A partially sent frame is abandoned; the encoder is responsible for the error termination.

Optional Feature:
- Macro: TXPAUSE_STATS_EN.
- Defined: adds output paused_cycles_o [31:0].
  - Increments each cycle in S_HOLD with tvalid_i = 1.
  - Saturates at FFFFFFFF.
  - Resets to 0 with rst.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
1. Idle link, one 3-beat user frame, tready_i = 1 → tvalid_o/tdata_o mirror the input in the same cycle; tready_o = 1 throughout.
2. rx_pause_active rises on beat 2 of a 4-beat frame (enable = 1) → all 4 beats pass; next frame is held (tready_o = 0) until pause drops, then passes. With TXPAUSE_STATS_EN, paused_cycles_o equals the hold cycles with tvalid_i = 1.
3. Same as 2 but cfg_tx_pause_enable = 0 → no hold; traffic unaffected.
4. tx_pause_req with quanta 16'hFFFF, cfg_src_mac 00:11:22:33:44:55, while held → 8 beats:
   - beat0 = 64'h1100_0100_00C2_8001 (bytes 0-7)
   - beat1 bytes 12-15 = 88 08 00 01
   - beat2[15:0] = 16'hFFFF
   - beat7 tkeep = 0F, tlast = 1
   - busy drops after beat7.
5. Pulse req (quanta 16'h0010) mid user frame, then req (quanta 16'h0000) before the boundary → one PAUSE frame after tlast carrying quanta 0000; tready_i toggling 1/0 stretches beats without dropping or duplicating any.
6. Assert rst during beat 4 of a PAUSE frame → next cycle tvalid_o = 0, busy = 0, state S_IDLE; a following user frame passes normally.

Source files
------------

// File: rtl/txpause_gate_if.sv
// TX AXIS path through txpause_gate: user-side inputs (*_i) and encoder-side outputs (*_o).
// A beat transfers on a clock edge where valid and ready are both high; the sender holds data until then.
interface txpause_gate_if;
  logic [63:0] tdata_i;
  logic [7:0]  tkeep_i;
  logic        tvalid_i;
  logic        tlast_i;
  logic        tuser_i;
  logic        tready_o;
  logic [63:0] tdata_o;
  logic [7:0]  tkeep_o;
  logic        tvalid_o;
  logic        tlast_o;
  logic        tuser_o;
  logic        tready_i;

  modport slave (
    input  tdata_i, tkeep_i, tvalid_i, tlast_i, tuser_i, tready_i,
    output tready_o, tdata_o, tkeep_o, tvalid_o, tlast_o, tuser_o
  );

  modport master (
    output tdata_i, tkeep_i, tvalid_i, tlast_i, tuser_i, tready_i,
    input  tready_o, tdata_o, tkeep_o, tvalid_o, tlast_o, tuser_o
  );
endinterface

// File: rtl/txpause_gate.sv
// TX pause gate: holds user frames at a boundary while paused and inserts local PAUSE frames.
// Optional macro TXPAUSE_STATS_EN adds paused_cycles_o (saturating count of held cycles with tvalid_i).
module txpause_gate (
  input  logic        clk,
  input  logic        rst,
  txpause_gate_if.slave bus,
  input  logic        rx_pause_active,
  input  logic        cfg_tx_pause_enable,
  input  logic [47:0] cfg_src_mac,
  input  logic        tx_pause_req,
  input  logic [15:0] tx_pause_quanta,
  output logic        tx_pause_busy,
  output logic [1:0]  state_dbg
`ifdef TXPAUSE_STATS_EN
  ,
  output logic [31:0] paused_cycles_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PFRAME = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t      state;
  logic        pend;
  logic [15:0] pend_quanta;
  logic [15:0] act_quanta;
  logic [2:0]  beat;

  logic        hold_cond;
  logic        pass;
  logic        pframe_on;
  logic        take;
  logic        acc_in;
  logic [63:0] pf_data;

  assign hold_cond = cfg_tx_pause_enable && rx_pause_active;
  assign acc_in    = bus.tvalid_i && bus.tready_i;
  assign take      = pend && (state == S_IDLE || state == S_HOLD);
  assign pframe_on = !rst && (state == S_PFRAME);
  assign state_dbg = state;
  assign tx_pause_busy = !rst && (pend || state == S_PFRAME);

  always_comb begin
    pass = 1'b0;
    case (state)
      S_IDLE:  pass = !pend && !hold_cond;
      S_DATA:  pass = 1'b1;
      default: pass = 1'b0;
    endcase
    if (rst) pass = 1'b0;
  end

  // Byte n of a beat sits at [8n+7:8n]; the MAC is sent most significant byte first.
  always_comb begin
    pf_data = '0;
    case (beat)
      3'd0: pf_data = {cfg_src_mac[39:32], cfg_src_mac[47:40], 48'h0100_00C2_8001};
      3'd1: pf_data = {32'h0100_0888, cfg_src_mac[7:0], cfg_src_mac[15:8],
                       cfg_src_mac[23:16], cfg_src_mac[31:24]};
      3'd2: pf_data = {48'h0, act_quanta[7:0], act_quanta[15:8]};
      default: pf_data = '0;
    endcase
  end

  always_comb begin
    bus.tready_o = pass && bus.tready_i;
    bus.tvalid_o = 1'b0;
    bus.tdata_o  = '0;
    bus.tkeep_o  = '0;
    bus.tlast_o  = 1'b0;
    bus.tuser_o  = 1'b0;
    if (pass && bus.tvalid_i) begin
      bus.tvalid_o = 1'b1;
      bus.tdata_o  = bus.tdata_i;
      bus.tkeep_o  = bus.tkeep_i;
      bus.tlast_o  = bus.tlast_i;
      bus.tuser_o  = bus.tuser_i;
    end else if (pframe_on) begin
      bus.tvalid_o = 1'b1;
      bus.tdata_o  = pf_data;
      bus.tkeep_o  = (beat == 3'd7) ? 8'h0F : 8'hFF;
      bus.tlast_o  = (beat == 3'd7);
      bus.tuser_o  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pend        <= 1'b0;
      pend_quanta <= '0;
      act_quanta  <= '0;
      beat        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend) begin
            state <= S_PFRAME;
            beat  <= '0;
          end else if (hold_cond) begin
            state <= S_HOLD;
          end else if (acc_in && !bus.tlast_i) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (acc_in && bus.tlast_i) state <= S_IDLE;
        end
        S_HOLD: begin
          if (pend) begin
            state <= S_PFRAME;
            beat  <= '0;
          end else if (!hold_cond) begin
            state <= S_IDLE;
          end
        end
        S_PFRAME: begin
          if (bus.tready_i) begin
            if (beat == 3'd7) state <= S_IDLE;
            beat <= beat + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (take) begin
        act_quanta <= pend_quanta;
        pend       <= 1'b0;
      end
      // A request on the hand-over cycle lands after the clear, so it queues another frame.
      if (tx_pause_req) begin
        pend        <= 1'b1;
        pend_quanta <= tx_pause_quanta;
      end
    end
  end

`ifdef TXPAUSE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      paused_cycles_o <= '0;
    end else if (state == S_HOLD && bus.tvalid_i && paused_cycles_o != 32'hFFFF_FFFF) begin
      paused_cycles_o <= paused_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_txpause_gate.sv
// Bench for txpause_gate: directed scenarios plus random traffic, all outputs checked every cycle
// against a frame-level model (user beats mirrored, PAUSE frames built byte by byte into a queue).
module tb_txpause_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_pause_active;
  logic        cfg_tx_pause_enable;
  logic [47:0] cfg_src_mac;
  logic        tx_pause_req;
  logic [15:0] tx_pause_quanta;
  logic        tx_pause_busy;
  logic [1:0]  state_dbg;
`ifdef TXPAUSE_STATS_EN
  logic [31:0] paused_cycles_o;
  logic [31:0] m_paused = '0;
`endif

  txpause_gate_if bus();

  txpause_gate dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .rx_pause_active     (rx_pause_active),
    .cfg_tx_pause_enable (cfg_tx_pause_enable),
    .cfg_src_mac         (cfg_src_mac),
    .tx_pause_req        (tx_pause_req),
    .tx_pause_quanta     (tx_pause_quanta),
    .tx_pause_busy       (tx_pause_busy),
    .state_dbg           (state_dbg)
`ifdef TXPAUSE_STATS_EN
    ,
    .paused_cycles_o     (paused_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [1:0] IDLE_ENC = 2'd0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: {last, keep, data} of the PAUSE frame still to be sent.
  logic [72:0] exp_q[$];
  bit          m_mid  = 0;
  bit          m_hold = 0;
  bit          m_pend = 0;
  logic [15:0] m_pend_q = '0;
  bit          acc = 0;
  logic [63:0] obs_beat0 = '0;
  logic [63:0] obs_beat2 = '0;
  int          dut_pf_cnt = 0;

  function automatic void build_pframe(logic [15:0] q);
    logic [7:0]  fb [64];
    logic [63:0] d;
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    fb[0] = 8'h01; fb[1] = 8'h80; fb[2] = 8'hC2;
    fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
    for (int i = 0; i < 6; i++) fb[6+i] = cfg_src_mac[47-8*i -: 8];
    fb[12] = 8'h88; fb[13] = 8'h08; fb[14] = 8'h00; fb[15] = 8'h01;
    fb[16] = q[15:8]; fb[17] = q[7:0];
    for (int b = 0; b < 8; b++) begin
      for (int n = 0; n < 8; n++) d[8*n +: 8] = fb[8*b+n];
      exp_q.push_back({(b == 7), (b == 7) ? 8'h0F : 8'hFF, d});
    end
  endfunction

  always @(negedge clk) begin : checker_blk
    logic        ev, er, el, eu, eb;
    logic [7:0]  ek;
    logic [63:0] ed;
    ev = 0; er = 0; el = 0; eu = 0; ek = '0; ed = '0;
    if (rst) begin
      ev = 0;
    end else if (exp_q.size() > 0) begin
      ev = 1; eu = 1;
      {el, ek, ed} = exp_q[0];
    end else if (m_hold || (!m_mid && (m_pend || (cfg_tx_pause_enable && rx_pause_active)))) begin
      ev = 0;
    end else begin
      ev = bus.tvalid_i;
      er = bus.tready_i;
      if (bus.tvalid_i) begin
        ed = bus.tdata_i; ek = bus.tkeep_i; el = bus.tlast_i; eu = bus.tuser_i;
      end
    end
    eb = !rst && (m_pend || exp_q.size() > 0);
    chk("tvalid_o", bus.tvalid_o, ev);
    chk("tready_o", bus.tready_o, er);
    chk("tdata_o",  bus.tdata_o,  ed);
    chk("tkeep_o",  bus.tkeep_o,  ek);
    chk("tlast_o",  bus.tlast_o,  el);
    chk("tuser_o",  bus.tuser_o,  eu);
    chk("busy",     tx_pause_busy, eb);
`ifdef TXPAUSE_STATS_EN
    chk("paused_cycles", paused_cycles_o, m_paused);
`endif
    acc = bus.tvalid_i && bus.tready_o;
    if (!rst && exp_q.size() == 8) obs_beat0 = bus.tdata_o;
    if (!rst && exp_q.size() == 6) obs_beat2 = bus.tdata_o;
    if (bus.tvalid_o && bus.tready_i && !bus.tready_o && bus.tlast_o) dut_pf_cnt++;

    if (rst) begin
      exp_q.delete();
      m_mid = 0; m_hold = 0; m_pend = 0; m_pend_q = '0;
`ifdef TXPAUSE_STATS_EN
      m_paused = '0;
`endif
    end else begin
`ifdef TXPAUSE_STATS_EN
      if (m_hold && bus.tvalid_i && m_paused != 32'hFFFF_FFFF) m_paused++;
`endif
      if (exp_q.size() > 0) begin
        if (bus.tready_i) void'(exp_q.pop_front());
      end else if (m_mid) begin
        if (bus.tvalid_i && bus.tready_i && bus.tlast_i) m_mid = 0;
      end else if (m_pend) begin
        build_pframe(m_pend_q);
        m_pend = 0; m_hold = 0;
      end else if (m_hold) begin
        if (!(cfg_tx_pause_enable && rx_pause_active)) m_hold = 0;
      end else if (cfg_tx_pause_enable && rx_pause_active) begin
        m_hold = 1;
      end else if (bus.tvalid_i && bus.tready_i) begin
        m_mid = !bus.tlast_i;
      end
      if (tx_pause_req) begin
        m_pend = 1; m_pend_q = tx_pause_quanta;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk); #1;
      tx_pause_req = 0;
    end
  endtask

  task automatic set_beat(bit last);
    bus.tvalid_i = 1;
    bus.tdata_i  = {$urandom, $urandom};
    bus.tkeep_i  = last ? 8'h0F : 8'hFF;
    bus.tlast_i  = last;
    bus.tuser_i  = 1;
  endtask

  task automatic wait_acc(string tag);
    int t;
    bit got;
    t = 0; got = 0;
    while (!got && t < 300) begin
      @(negedge clk); #1;
      got = acc;
      t++;
      @(posedge clk); #1;
      tx_pause_req = 0;
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic send_frame(int n);
    for (int b = 0; b < n; b++) begin
      set_beat(b == n - 1);
      wait_acc("frame");
    end
    bus.tvalid_i = 0; bus.tlast_i = 0;
  endtask

  task automatic pulse_req(logic [15:0] q);
    tx_pause_req = 1; tx_pause_quanta = q;
    step(1);
  endtask

  task automatic wait_not_busy(string tag);
    int t;
    t = 0;
    while (tx_pause_busy && t < 300) begin
      step(1);
      t++;
    end
    if (tx_pause_busy) chk({tag, "_busy_timeout"}, 0, 1);
  endtask

  initial begin
    int rem;
    int base;
    int t;
    rst = 1;
    rx_pause_active = 0; cfg_tx_pause_enable = 1;
    cfg_src_mac = 48'h0011_2233_4455;
    tx_pause_req = 0; tx_pause_quanta = '0;
    bus.tdata_i = '0; bus.tkeep_i = '0; bus.tvalid_i = 0;
    bus.tlast_i = 0; bus.tuser_i = 0; bus.tready_i = 1;
    step(3);
    rst = 0;
    chk("reset_state", state_dbg, IDLE_ENC);
    chk("reset_busy", tx_pause_busy, 0);

    // 1: plain 3-beat frame
    send_frame(3);
    step(2);

    // 2: pause rises on beat 2; current frame completes, next one held
    for (int b = 0; b < 4; b++) begin
      set_beat(b == 3);
      if (b == 1) rx_pause_active = 1;
      wait_acc("t2_frame");
    end
    set_beat(0);
    step(8);
    chk("t2_held", bus.tready_o, 0);
    rx_pause_active = 0;
    wait_acc("t2_resume");
    set_beat(1);
    wait_acc("t2_resume_last");
    bus.tvalid_i = 0; bus.tlast_i = 0;
    step(2);

    // 3: gating disabled
    cfg_tx_pause_enable = 0; rx_pause_active = 1;
    send_frame(3);
    rx_pause_active = 0; cfg_tx_pause_enable = 1;
    step(2);

    // 4: PAUSE XOFF while held
    rx_pause_active = 1;
    set_beat(0);
    step(4);
    pulse_req(16'hFFFF);
    wait_not_busy("t4");
    chk("t4_beat0", obs_beat0, 64'h1100_0100_00C2_8001);
    chk("t4_quanta", obs_beat2[15:0], 16'hFFFF);
    rx_pause_active = 0;
    wait_acc("t4_user");
    set_beat(1);
    wait_acc("t4_user_last");
    bus.tvalid_i = 0; bus.tlast_i = 0;
    step(2);

    // 5: two requests mid-frame, latest quanta wins, stalled encoder
    base = dut_pf_cnt;
    set_beat(0); tx_pause_req = 1; tx_pause_quanta = 16'h0010;
    wait_acc("t5_b0");
    set_beat(0); tx_pause_req = 1; tx_pause_quanta = 16'h0000;
    wait_acc("t5_b1");
    set_beat(1);
    wait_acc("t5_b2");
    bus.tvalid_i = 0; bus.tlast_i = 0;
    for (int i = 0; i < 30; i++) begin
      bus.tready_i = ~bus.tready_i;
      step(1);
    end
    bus.tready_i = 1;
    step(4);
    chk("t5_frames", dut_pf_cnt - base, 1);
    chk("t5_quanta", obs_beat2[15:0], 16'h0000);

    // 6: reset in the middle of a PAUSE frame
    pulse_req(16'h1234);
    t = 0;
    while (exp_q.size() != 4 && t < 100) begin step(1); t++; end
    if (exp_q.size() != 4) chk("t6_reach_beat4_timeout", 0, 1);
    rst = 1;
    step(1);
    rst = 0;
    chk("t6_state", state_dbg, IDLE_ENC);
    chk("t6_tvalid", bus.tvalid_o, 0);
    chk("t6_busy", tx_pause_busy, 0);
    send_frame(2);
    step(2);

    // random traffic
    cfg_src_mac = {$urandom, $urandom};
    rem = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!bus.tvalid_i || acc) begin
        if (rem == 0 && $urandom_range(0, 3) == 0) begin
          bus.tvalid_i = 0; bus.tlast_i = 0;
        end else begin
          if (rem == 0) rem = $urandom_range(1, 5);
          bus.tvalid_i = 1;
          bus.tdata_i  = {$urandom, $urandom};
          bus.tlast_i  = (rem == 1);
          bus.tkeep_i  = (rem == 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
          bus.tuser_i  = 1'($urandom_range(0, 1));
          rem--;
        end
      end
      bus.tready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) rx_pause_active = ~rx_pause_active;
      if ($urandom_range(0, 99) == 0) cfg_tx_pause_enable = ~cfg_tx_pause_enable;
      if ($urandom_range(0, 24) == 0) begin
        tx_pause_req = 1;
        tx_pause_quanta = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      end
      @(posedge clk); #1;
      tx_pause_req = 0;
    end
    bus.tvalid_i = 0; bus.tlast_i = 0; bus.tready_i = 1;
    rx_pause_active = 0;
    step(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
